// File: rtl/button_conditioner_if.sv
// Button bundle between raw push-buttons and the conditioned outputs
// consumed by the stopwatch FSM.
interface button_conditioner_if #(
    parameter int N_BTN = 2
);
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_press_slow;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_press_slow
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_press_slow
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-channel synchronizer, debounce FSM and press-pulse stretcher so each
// physical press yields exactly one pulse visible to the 1 kHz stopwatch FSM.
module button_conditioner #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int PULSE_CYCLES    = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam int STR_W = $clog2(PULSE_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STR_W-1:0] STR_ZERO = STR_W'(0);
    localparam logic [STR_W-1:0] STR_ONE  = STR_W'(1);
    localparam logic [STR_W-1:0] STR_LOAD = STR_W'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE            = 2'd0,
        CONFIRM_PRESS   = 2'd1,
        PRESSED         = 2'd2,
        CONFIRM_RELEASE = 2'd3
    } state_t;

    logic [N_BTN-1:0] level_s;
    logic [N_BTN-1:0] press_s;
    logic [N_BTN-1:0] slow_s;

    for (genvar g = 0; g < N_BTN; g++) begin : g_chan
        logic             sync1_r;
        logic             sync2_r;
        state_t           state_r;
        state_t           state_nxt_s;
        logic [CNT_W-1:0] cnt_r;
        logic [CNT_W-1:0] cnt_nxt_s;
        logic             level_r;
        logic             level_nxt_s;
        logic             press_r;
        logic             press_nxt_s;
        logic             slow_r;
        logic [STR_W-1:0] str_cnt_r;
        logic             at_term_s;

        assign at_term_s = (cnt_r == CNT_TERM);

        // Two-flop synchronizer for the raw asynchronous button.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                sync1_r <= 1'b0;
                sync2_r <= 1'b0;
            end else begin
                sync1_r <= bus.btn_in[g];
                sync2_r <= sync1_r;
            end
        end

        // State register with the debounce counter and registered outputs.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_r <= IDLE;
                cnt_r   <= CNT_ZERO;
                level_r <= 1'b0;
                press_r <= 1'b0;
            end else begin
                state_r <= state_nxt_s;
                cnt_r   <= cnt_nxt_s;
                level_r <= level_nxt_s;
                press_r <= press_nxt_s;
            end
        end

        // Next-state and debounce counter logic.
        always_comb begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r;
            case (state_r)
                IDLE: begin
                    if (sync2_r) begin
                        state_nxt_s = CONFIRM_PRESS;
                        cnt_nxt_s   = CNT_ONE;
                    end else begin
                        cnt_nxt_s   = CNT_ZERO;
                    end
                end
                CONFIRM_PRESS: begin
                    if (!sync2_r) begin
                        state_nxt_s = IDLE;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (at_term_s) begin
                        state_nxt_s = PRESSED;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!sync2_r) begin
                        state_nxt_s = CONFIRM_RELEASE;
                        cnt_nxt_s   = CNT_ONE;
                    end else begin
                        cnt_nxt_s   = CNT_ZERO;
                    end
                end
                CONFIRM_RELEASE: begin
                    if (sync2_r) begin
                        state_nxt_s = PRESSED;
                        cnt_nxt_s   = CNT_ZERO;
                    end else if (at_term_s) begin
                        state_nxt_s = IDLE;
                        cnt_nxt_s   = CNT_ZERO;
                    end else begin
                        cnt_nxt_s   = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end
            endcase
        end

        // Output decode: level follows accepted transitions, press only on acceptance.
        always_comb begin
            level_nxt_s = level_r;
            press_nxt_s = 1'b0;
            case (state_r)
                CONFIRM_PRESS: begin
                    if (sync2_r && at_term_s) begin
                        level_nxt_s = 1'b1;
                        press_nxt_s = 1'b1;
                    end else begin
                        press_nxt_s = 1'b0;
                    end
                end
                CONFIRM_RELEASE: begin
                    if (!sync2_r && at_term_s) begin
                        level_nxt_s = 1'b0;
                    end else begin
                        level_nxt_s = level_r;
                    end
                end
                default: begin
                    press_nxt_s = 1'b0;
                end
            endcase
        end

        // Stretcher: holds the press for one slow-clock period; presses while busy are dropped.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                slow_r    <= 1'b0;
                str_cnt_r <= STR_ZERO;
            end else if (slow_r) begin
                if (str_cnt_r == STR_ZERO) begin
                    slow_r <= 1'b0;
                end else begin
                    str_cnt_r <= str_cnt_r - STR_ONE;
                end
            end else if (press_r) begin
                slow_r    <= 1'b1;
                str_cnt_r <= STR_LOAD;
            end else begin
                str_cnt_r <= STR_ZERO;
            end
        end

        assign level_s[g] = level_r;
        assign press_s[g] = press_r;
        assign slow_s[g]  = slow_r;
    end

    assign bus.btn_level      = level_s;
    assign bus.btn_press      = press_s;
    assign bus.btn_press_slow = slow_s;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=8, PULSE_CYCLES=5.
module tb_button_conditioner;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   press_n [2];
    int   slow_n  [2];
    int   lvl_n   [2];
    int   b_press [2];
    int   b_slow  [2];
    int   b_lvl   [2];

    button_conditioner_if #(.N_BTN(2)) bif ();

    button_conditioner #(
        .N_BTN(2),
        .DEBOUNCE_CYCLES(8),
        .PULSE_CYCLES(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-channel activity counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                press_n[i] = press_n[i] + int'(bif.btn_press[i]);
                slow_n[i]  = slow_n[i]  + int'(bif.btn_press_slow[i]);
                lvl_n[i]   = lvl_n[i]   + int'(bif.btn_level[i]);
            end
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 2; i++) begin
            b_press[i] = press_n[i];
            b_slow[i]  = slow_n[i];
            b_lvl[i]   = lvl_n[i];
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 2; i++) begin
            press_n[i] = 0;
            slow_n[i]  = 0;
            lvl_n[i]   = 0;
        end
        reset = 1'b1;
        bif.btn_in = 2'b00;
        tick(3);
        chk("rst_level", int'(bif.btn_level), 0);
        chk("rst_press", int'(bif.btn_press), 0);
        chk("rst_slow",  int'(bif.btn_press_slow), 0);
        reset = 1'b0;
        tick(2);

        // Clean press on channel 0
        snap();
        bif.btn_in = 2'b01;
        tick(9);
        chk("clean_level_early", int'(bif.btn_level), 0);
        chk("clean_press_early", int'(bif.btn_press), 0);
        tick(1);
        chk("clean_level", int'(bif.btn_level), 1);
        chk("clean_press", int'(bif.btn_press), 1);
        chk("clean_slow_before", int'(bif.btn_press_slow), 0);
        tick(1);
        chk("clean_press_1cyc", int'(bif.btn_press), 0);
        chk("clean_slow_start", int'(bif.btn_press_slow), 1);
        tick(4);
        chk("clean_slow_last", int'(bif.btn_press_slow), 1);
        tick(1);
        chk("clean_slow_end", int'(bif.btn_press_slow), 0);
        tick(24);
        chk("clean_press_count", press_n[0] - b_press[0], 1);
        chk("clean_slow_count", slow_n[0] - b_slow[0], 5);
        bif.btn_in = 2'b00;
        tick(9);
        chk("release_level_held", int'(bif.btn_level), 1);
        tick(1);
        chk("release_level_fall", int'(bif.btn_level), 0);
        tick(10);
        chk("release_no_pulse", press_n[0] - b_press[0], 1);

        // Bouncing press on channel 0
        snap();
        for (int k = 0; k < 2; k++) begin
            bif.btn_in = 2'b01;
            tick(3);
            bif.btn_in = 2'b00;
            tick(3);
        end
        bif.btn_in = 2'b01;
        tick(9);
        chk("bounce_press_early", press_n[0] - b_press[0], 0);
        chk("bounce_level_early", int'(bif.btn_level), 0);
        tick(1);
        chk("bounce_press", int'(bif.btn_press), 1);
        tick(20);
        chk("bounce_press_count", press_n[0] - b_press[0], 1);
        chk("bounce_ch1_press", press_n[1] - b_press[1], 0);
        chk("bounce_ch1_level", lvl_n[1] - b_lvl[1], 0);
        chk("bounce_ch1_slow", slow_n[1] - b_slow[1], 0);
        bif.btn_in = 2'b00;
        tick(15);

        // Short glitch on channel 1
        snap();
        bif.btn_in = 2'b10;
        tick(6);
        bif.btn_in = 2'b00;
        tick(20);
        chk("glitch_level", lvl_n[1] - b_lvl[1], 0);
        chk("glitch_press", press_n[1] - b_press[1], 0);
        chk("glitch_slow", slow_n[1] - b_slow[1], 0);

        // Simultaneous press on both channels
        snap();
        bif.btn_in = 2'b11;
        tick(9);
        chk("simul_press_early", int'(bif.btn_press), 0);
        tick(1);
        chk("simul_press", int'(bif.btn_press), 3);
        chk("simul_level", int'(bif.btn_level), 3);
        tick(1);
        chk("simul_slow_start", int'(bif.btn_press_slow), 3);
        tick(4);
        chk("simul_slow_last", int'(bif.btn_press_slow), 3);
        tick(1);
        chk("simul_slow_end", int'(bif.btn_press_slow), 0);
        chk("simul_slow_count0", slow_n[0] - b_slow[0], 5);
        chk("simul_slow_count1", slow_n[1] - b_slow[1], 5);

        // Release bounce on channel 0 while pressed
        tick(5);
        snap();
        bif.btn_in = 2'b10;
        tick(4);
        bif.btn_in = 2'b11;
        tick(20);
        chk("relbounce_level_cycles", lvl_n[0] - b_lvl[0], 24);
        chk("relbounce_no_press", press_n[0] - b_press[0], 0);
        chk("relbounce_level", int'(bif.btn_level), 3);
        bif.btn_in = 2'b00;
        tick(15);
        chk("relbounce_idle", int'(bif.btn_level), 0);

        // Reset in the middle of CONFIRM_PRESS
        bif.btn_in = 2'b01;
        tick(5);
        reset = 1'b1;
        #1;
        chk("rst_confirm_level", int'(bif.btn_level), 0);
        tick(2);
        reset = 1'b0;
        snap();
        tick(9);
        chk("rst_confirm_press_early", press_n[0] - b_press[0], 0);
        tick(1);
        chk("rst_confirm_press", int'(bif.btn_press), 1);
        tick(2);
        chk("rst_stretch_slow_on", int'(bif.btn_press_slow), 1);

        // Reset during the stretch
        reset = 1'b1;
        #1;
        chk("rst_stretch_slow", int'(bif.btn_press_slow), 0);
        chk("rst_stretch_level", int'(bif.btn_level), 0);
        chk("rst_stretch_press", int'(bif.btn_press), 0);
        tick(1);
        reset = 1'b0;
        snap();
        tick(9);
        chk("rst_after_press_early", press_n[0] - b_press[0], 0);
        chk("rst_after_slow_early", slow_n[0] - b_slow[0], 0);
        tick(1);
        chk("rst_after_press", int'(bif.btn_press), 1);
        chk("rst_after_level", int'(bif.btn_level), 1);
        tick(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Input conditioning stage directly upstream of the stopwatch FSM. Conditions the raw start_stop and clear push-buttons in the 100 MHz domain.
- Per button: 2-flop synchronizer, then a 4-state debounce FSM. Produces a debounced level, a 1-cycle press pulse, and a stretched press pulse sized for the 1 kHz FSM clock.
- The stretched pulse is seen on exactly one rising edge of clk_1khz, so each physical press causes exactly one start/stop toggle or clear.

Parameters:
- N_BTN, 2, number of independent button channels (bit 0 = start_stop, bit 1 = clear).
- DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles needed to accept a level change (10 ms at 100 MHz); must be >= 2.
- PULSE_CYCLES, 100000, width of btn_press_slow in clk cycles; equals one clk_1khz period; must be < DEBOUNCE_CYCLES.

Ports:
- clk  input  1  100 MHz system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- btn_in  input  N_BTN  raw asynchronous button inputs, active-high, may bounce.
- btn_level  output  N_BTN  debounced, synchronized button level.
- btn_press  output  N_BTN  1-clk pulse per accepted press (0->1 of btn_level).
- btn_press_slow  output  N_BTN  press pulse held high for exactly PULSE_CYCLES clk cycles.

Behaviour:
- Reset: all outputs 0; sync flops 0; every channel in IDLE; all counters 0. Reset asserted mid-count or mid-stretch aborts immediately, with no pulse on release of reset.
- Synchronizer: two flops per channel; sync = second-flop output. The FSM uses only sync.
- Counter: one debounce counter per channel, width clog2(DEBOUNCE_CYCLES). Saturating behaviour is not needed; the FSM leaves the CONFIRM state at the terminal count.
- IDLE: sync=1 -> CONFIRM_PRESS, cnt=1. Otherwise stay, cnt=0.
- CONFIRM_PRESS:
  - sync=0 -> IDLE, cnt=0 (glitch rejected, no output change).
  - sync=1 and cnt=DEBOUNCE_CYCLES-1 -> PRESSED. On that edge btn_level<=1 and btn_press<=1.
  - Otherwise cnt++.
- PRESSED: btn_press<=0 next cycle. sync=0 -> CONFIRM_RELEASE, cnt=1.
- CONFIRM_RELEASE:
  - sync=1 -> PRESSED, cnt=0.
  - sync=0 and cnt=DEBOUNCE_CYCLES-1 -> IDLE, btn_level<=0.
  - Otherwise cnt++.
  - Releases produce no pulse.
- Latency: for a clean 0->1 on btn_in that meets setup at edge k, btn_level and btn_press are high after edge k+1+DEBOUNCE_CYCLES. The same figure applies to the btn_level fall on release.
- Stretch: when btn_press=1, btn_press_slow<=1 and stretch counter<=PULSE_CYCLES-1. The counter decrements each cycle; btn_press_slow<=0 on the edge after it reaches 0.
  - Total high time is exactly PULSE_CYCLES cycles.
  - A new btn_press while stretching is ignored (cannot occur when PULSE_CYCLES < DEBOUNCE_CYCLES).
- Channels are fully independent. Simultaneous presses on both channels are each processed and pulsed in the same cycle; no priority.
- Input held high indefinitely: one btn_press only, btn_level stays 1, no auto-repeat.

Test Plan (sim with DEBOUNCE_CYCLES=8, PULSE_CYCLES=5, N_BTN=2):
- Clean press: btn_in[0] 0->1 before edge 10, held 40 cycles -> btn_level[0] and btn_press[0] rise after edge 19; btn_press[0] is high 1 cycle; btn_press_slow[0] is high 5 cycles (after edges 20-24); btn_level[0] falls 9 cycles after release; no release pulse.
- Bounce: btn_in[0] toggles 1,0,1,0 with 3-cycle periods, then stable 1 -> exactly one btn_press[0], timed from the last rising bounce plus 9 cycles; channel 1 outputs stay 0.
- Short glitch: btn_in[1] high for 6 cycles, then low -> btn_level[1], btn_press[1] and btn_press_slow[1] never assert; channel returns to IDLE.
- Simultaneous: both bits rise on the same cycle -> btn_press=2'b11 on the same cycle; btn_press_slow=2'b11 for 5 cycles.
- Release bounce: while PRESSED, btn_in[0] drops for 4 cycles, then returns high -> btn_level[0] stays 1 and no second btn_press.
- Reset mid-operation: reset asserted in the middle of CONFIRM_PRESS, and separately during the stretch -> all outputs 0 immediately (asynchronous). After reset deasserts with btn_in still high, one full debounce (9 cycles) elapses before btn_press.
